// File: rtl/cmdout_scheduler_if.sv
// MemoryPort32: single-port 64-bit memory bus with per-byte write enables.
// Reads have one cycle of latency; the write and the read of the same cycle both use addr.
interface MemoryPort32;
   logic        en;
   logic [7:0]  wr;
   logic [31:0] addr;
   logic [63:0] din;
   logic [63:0] dout;

   modport master (output en, output wr, output addr, output din, input dout);
   modport slave  (input en, input wr, input addr, input din, output dout);
endinterface

// File: rtl/cmdout_scheduler.sv
// cmdout_scheduler: round-robin drain engine for the per-accelerator cmd-out queues.
// Optional macro CMDOUT_BURST_EN: drain up to MAX_BURST entries per accelerator visit.
//
// state     | meaning
// SCAN      | select acc; issue header read when its mask bit is set
// CHECK_HDR | header on dout; issue task-id read when header is valid
// READ_TID  | task id on dout; latch record and raise out_valid
// OUTPUT    | record presented, waiting for out_ready
// CLEAR     | write 0 to header valid byte, advance slot pointer
module cmdout_scheduler #(
   parameter  int NUM_ACCS  = 16,
   parameter  int MAX_BURST = 4,
   localparam int ACC_BITS  = (NUM_ACCS > 1) ? $clog2(NUM_ACCS) : 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NUM_ACCS-1:0] acc_mask,
   MemoryPort32.master         cmdoutPort,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [63:0]         out_tid,
   output logic [ACC_BITS-1:0] out_acc,
   output logic [31:0]         cmd_count
);

   typedef enum logic [2:0] {
      SCAN      = 3'd0,
      CHECK_HDR = 3'd1,
      READ_TID  = 3'd2,
      OUTPUT    = 3'd3,
      CLEAR     = 3'd4
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ACC_BITS-1:0] acc;
   logic [ACC_BITS-1:0] acc_inc;
   logic [5:0]          slot_ptr [NUM_ACCS];
   logic [5:0]          slot_cur;
   logic                acc_en;
   logic                hdr_valid;
   logic                acc_step;
   logic                advance_after_clear;

   assign slot_cur  = slot_ptr[acc];
   assign acc_en    = acc_mask[acc];
   assign hdr_valid = (cmdoutPort.dout[63:56] == 8'h80);
   assign acc_inc   = (acc == ACC_BITS'(NUM_ACCS - 1)) ? '0 : acc + 1'b1;

   assign acc_step = ((state == SCAN) && !acc_en) ||
                     ((state == CHECK_HDR) && !hdr_valid) ||
                     ((state == CLEAR) && advance_after_clear);

`ifdef CMDOUT_BURST_EN
   localparam int BURST_BITS = $clog2(MAX_BURST + 1);

   logic [BURST_BITS-1:0] burst_cnt;

   assign advance_after_clear = ((burst_cnt + 1'b1) == BURST_BITS'(MAX_BURST));

   // Any acc change (mask skip, empty header, burst end) restarts the burst.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         burst_cnt <= '0;
      end else if (acc_step) begin
         burst_cnt <= '0;
      end else if (state == CLEAR) begin
         burst_cnt <= burst_cnt + 1'b1;
      end
   end
`else
   logic unused_burst_cfg;

   assign unused_burst_cfg    = (MAX_BURST != 0);
   assign advance_after_clear = 1'b1;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= SCAN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SCAN:      if (acc_en) state_nxt = CHECK_HDR;
         CHECK_HDR: state_nxt = hdr_valid ? READ_TID : SCAN;
         READ_TID:  state_nxt = OUTPUT;
         OUTPUT:    if (out_valid && out_ready) state_nxt = CLEAR;
         CLEAR:     state_nxt = SCAN;
         default:   state_nxt = SCAN;
      endcase
   end

   // Header address of (acc, slot) unless the task-id word is being fetched.
   always_comb begin
      cmdoutPort.en                  = 1'b1;
      cmdoutPort.wr                  = 8'h00;
      cmdoutPort.din                 = '0;
      cmdoutPort.addr                = '0;
      cmdoutPort.addr[9 +: ACC_BITS] = acc;
      cmdoutPort.addr[8:3]           = slot_cur;
      if ((state == CHECK_HDR) && hdr_valid) begin
         cmdoutPort.addr[3] = 1'b1;
      end
      if (state == CLEAR) begin
         cmdoutPort.wr = 8'h80;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc       <= '0;
         out_valid <= 1'b0;
         out_tid   <= '0;
         out_acc   <= '0;
         cmd_count <= '0;
         for (int i = 0; i < NUM_ACCS; i++) begin
            slot_ptr[i] <= '0;
         end
      end else begin
         if (acc_step) begin
            acc <= acc_inc;
         end
         case (state)
            READ_TID: begin
               out_tid   <= cmdoutPort.dout;
               out_acc   <= acc;
               out_valid <= 1'b1;
            end
            OUTPUT: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  cmd_count <= cmd_count + 32'd1;
               end
            end
            CLEAR: begin
               slot_ptr[acc] <= slot_cur + 6'd2;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/cmdout_scheduler.md
Name: cmdout_scheduler

Overview:
- Synthesizable drain engine for the per-accelerator command-out queues held in the 64-bit cmd-out memory.
- Scans accelerator queues round-robin and detects valid entries, where the header byte equals 0x80.
- Fetches each task id, presents it on a ready/valid stream to the task-completion logic, then releases the slot by clearing the header valid byte.
- Sits between the cmd-out memory's master port and the scheduler/taskwait side of the manager.

Parameters:
- NUM_ACCS, 16: number of accelerator queues. Local ACC_BITS = max(1, clog2(NUM_ACCS)).
- MAX_BURST, 4: maximum entries drained from one accelerator before moving on. Used only with CMDOUT_BURST_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- acc_mask  in  NUM_ACCS  per-accelerator scan enable (1 = scan)
- cmdoutPort  MemoryPort32.master  -  cmd-out memory: en, wr[7:0] byte enables, addr[31:0], din[63:0], dout[63:0]; read latency 1 cycle
- out_valid  out  1  finished-task record valid
- out_ready  in  1  consumer accepts record
- out_tid  out  64  task id word
- out_acc  out  ACC_BITS  source accelerator
- cmd_count  out  32  number of records handed off; wraps at 2^32

Behaviour:
- Memory layout:
  - addr[8:3] = slot (64 words per accelerator); addr[9+ACC_BITS-1:9] = acc; all other address bits 0.
  - Entry = header word at slot s, task-id word at s+1. Header valid iff dout[63:56] == 8'h80; any other value means empty.
- Per-accelerator slot pointer: 6-bit, even values only, +2 per drained entry, wraps 62 -> 0.
- cmdoutPort.en held 1. wr = 8'h00 except in CLEAR. din = 0.
- Reset (async, rstn=0):
  - state = SCAN; acc = 0; all slot pointers 0; out_valid = 0; out_tid = 0; out_acc = 0; cmd_count = 0; burst count 0.
  - Any in-flight entry is abandoned: no clear write occurs, and the entry is re-found after reset.
- State SCAN:
  - If acc_mask[acc] == 0: acc <= (acc+1) % NUM_ACCS; stay in SCAN. Skips cost 1 cycle each.
  - Else: addr = header of (acc, slot); go to CHECK_HDR.
  - acc_mask is sampled only in SCAN. If all bits are 0, the block spins in SCAN issuing no writes.
- State CHECK_HDR:
  - dout holds the header.
  - If valid: addr = slot+1 in the same cycle; go to READ_TID.
  - Else: acc advances; go to SCAN.
- State READ_TID: out_tid <= dout; out_acc <= acc; out_valid <= 1; go to OUTPUT.
- State OUTPUT:
  - out_tid and out_acc are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0; cmd_count <= cmd_count + 1; go to CLEAR.
- State CLEAR:
  - addr = header of (acc, slot); wr = 8'h80; din = 0. This clears byte 7 only.
  - slot <= slot + 2; acc advances; go to SCAN.
- Latency:
  - Valid header read in SCAN at cycle 0 -> out_valid high at cycle 3.
  - Handshake at cycle N -> clear write at cycle N+1 -> next SCAN at cycle N+2.
- Fairness: every enabled accelerator is visited at least once per NUM_ACCS entry-or-empty visits.
- A record is never emitted twice for one header write: the clear completes before that slot pointer is revisited.

Optional Feature:
- Macro CMDOUT_BURST_EN.
- Defined:
  - After CLEAR, acc advances only if burst_cnt+1 == MAX_BURST; otherwise SCAN re-reads the same accelerator at its new slot.
  - burst_cnt resets to 0 on every acc change, including the change caused by an empty header.
  - An accelerator whose mask bit drops mid-burst is left at its next SCAN.
- Undefined: acc advances after every CLEAR; no burst counter is instantiated.

Test Plan:
- Reset then empty memory, acc_mask=16'hFFFF -> no writes, acc cycles 0..15 repeatedly, out_valid stays 0, cmd_count=0.
- Acc 3 slot 0: header 0x80.., word1=64'h0000_0042_0000_0007; out_ready=1 -> out_tid=64'h0000_0042_0000_0007, out_acc=3, out_valid rises 3 cycles after header read; next cycle wr=8'h80 to addr 0x600; cmd_count=1; acc 3 slot pointer = 2.
- Same entry with out_ready=0 for 10 cycles -> out_tid/out_acc stable and no write during stall; clear occurs exactly 1 cycle after out_ready rises.
- Acc 5 filled with 32 entries, refilled after drain -> 33rd entry read at slot 0 (wrap); 33 distinct tids emitted in order.
- acc_mask=16'h0004 with entries in acc 1 and acc 2 -> only acc 2 drained; acc 1 entries untouched. Set mask bit 1 -> acc 1 drained.
- rstn pulsed low during OUTPUT -> out_valid=0 immediately; header stays 0x80; after release the same tid is re-emitted once. With CMDOUT_BURST_EN and MAX_BURST=4, 6 entries in acc 0 and 1 entry in acc 1 -> order acc0 x4, acc1 x1, acc0 x2.
